wide_add_seq: RTL and testbench
===============================

// Module: wide_add_seq
// PURPOSE
//  Multi-word add sequencer driving the registered 32-bit lookahead adder stage.
//  Splits two NWORDS*WORD_W operands into words and issues them LSW first.
//  Chains each word's carry-out into the next word's carry-in and assembles the wide sum.
//  Upstream side: valid/ready operand port. Downstream side: valid/ready result port.
// PARAMETERS
//  WORD_W   32  adder word width; must match the attached adder stage
//  NWORDS   4   words per operand; full width is NWORDS*WORD_W (128 by default)
//  ADD_LAT  1   adder latency in clocks, operands-sampled edge to sum/cout valid; >=1
// PORTS
//  clk       in   1               single clock, rising edge
//  rst       in   1               asynchronous, active-high reset
//  in_valid  in   1               operand request
//  in_ready  out  1               sequencer idle, can accept request
//  in_a      in   NWORDS*WORD_W   operand A
//  in_b      in   NWORDS*WORD_W   operand B
//  in_cin    in   1               carry into word 0
//  add_a     out  WORD_W          to adder a
//  add_b     out  WORD_W          to adder b
//  add_cin   out  1               to adder cin
//  add_sum   in   WORD_W          from adder sum
//  add_cout  in   1               from adder cout
//  out_valid out  1               result available
//  out_ready in   1               downstream accepts result
//  out_sum   out  NWORDS*WORD_W   wide sum
//  out_cout  out  1               carry out of the top word
//  out_ovf   out  1               signed overflow of the full-width add; see CONFIGURATION
// BEHAVIOUR
//  Reset: all state clears immediately and asynchronously. State returns to IDLE.
//  Reset values: all outputs are 0, including in_ready.
//  in_ready is registered: it goes to 1 on the first clock edge after rst deasserts.
//  FSM states: IDLE, ISSUE, WAIT, DONE. in_ready=1 only in IDLE.
//  IDLE: on in_valid&&in_ready, latch in_a/in_b/in_cin, set word index=0, carry=in_cin.
//   The next state is ISSUE.
//  ISSUE, 1 cycle: drive add_a/add_b with word[idx], drive add_cin with carry.
//   Load the wait counter with ADD_LAT. The next state is WAIT.
//  WAIT, ADD_LAT cycles: decrement the counter each cycle. When the counter is 1, capture add_sum into out_sum slice idx and add_cout into carry.
//   If idx==NWORDS-1, go to DONE. Otherwise increment idx and go to ISSUE.
//  Outside ISSUE, add_a/add_b/add_cin are driven 0. Adder results sampled from those cycles are ignored.
//  DONE: out_valid=1. out_cout = final carry. out_sum and out_cout are held stable while !out_ready.
//  On out_valid&&out_ready, go to IDLE. A new request is accepted the following cycle at the earliest.
//  Latency: out_valid goes high NWORDS*(ADD_LAT+1)+1 cycles after the accepting cycle. For defaults this is 9.
//  Throughput: one operation per NWORDS*(ADD_LAT+1)+2 cycles when out_ready is held high.
//  in_valid is ignored outside IDLE. Input operands may change after acceptance without effect.
//  Arithmetic: out_sum = (in_a+in_b+in_cin) mod 2^(NWORDS*WORD_W). out_cout = bit NWORDS*WORD_W of that sum.
//  out_sum slices not yet written in the current operation hold their previous values. They are only observable when out_valid=1.
//  If rst asserts mid-operation, the operation is aborted and discarded. No partial result is emitted.
// CONFIGURATION
//  WADD_OVF_EN defined: out_ovf is registered with out_sum. It is (a_msb==b_msb)&&(sum_msb!=a_msb), using full-width MSBs.
//   out_ovf is valid with out_valid and is 0 in reset.
//  WADD_OVF_EN undefined: out_ovf is tied 0, and no MSB capture logic is built.
// TESTING
//  All tests use defaults and a bench model of the adder with ADD_LAT=1.
//  1) Carry ripple: A=all-ones(128), B=1, cin=0 -> out_sum=0, out_cout=1. out_valid is high 9 cycles after accept.
//  2) Carry-in only: A=0, B=0, cin=1 -> out_sum=128'h1, out_cout=0.
//  3) Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_sum/out_valid stay stable and in_ready stays 0.
//   Releasing out_ready gives one handshake, then in_ready=1 the next cycle.
//  4) Reset mid-op: assert rst during WAIT of word 2 -> all outputs go 0 at once, and out_valid never pulses.
//   A fresh add after reset gives the correct result.
//  5) Back-to-back: 3 random ops with in_valid and out_ready held high -> results match the reference model, spaced 10 cycles apart.
//  6) WADD_OVF_EN: A=0x7FFF..F, B=1 -> out_ovf=1. A=0x7FFF..F, B=0x80..0 -> out_ovf=0. Without the macro, out_ovf is always 0.

Source files
------------

// File: rtl/wide_add_seq.sv
// Multi-word add sequencer: splits wide operands into words, issues them LSW first to an external
// registered adder, chains carries, assembles the wide sum. Optional signed overflow via WADD_OVF_EN.
module wide_add_seq #(
   parameter int WORD_W  = 32,
   parameter int NWORDS  = 4,
   parameter int ADD_LAT = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NWORDS*WORD_W-1:0] in_a,
   input  logic [NWORDS*WORD_W-1:0] in_b,
   input  logic                     in_cin,
   output logic [WORD_W-1:0]        add_a,
   output logic [WORD_W-1:0]        add_b,
   output logic                     add_cin,
   input  logic [WORD_W-1:0]        add_sum,
   input  logic                     add_cout,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NWORDS*WORD_W-1:0] out_sum,
   output logic                     out_cout,
   output logic                     out_ovf
);

   localparam int FULL_W = NWORDS * WORD_W;
   localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam int CNT_W  = $clog2(ADD_LAT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [FULL_W-1:0]   a_q, a_d;
   logic [FULL_W-1:0]   b_q, b_d;
   logic [FULL_W-1:0]   out_sum_q, out_sum_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                carry_q, carry_d;
   logic                in_ready_q, in_ready_d;

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      out_sum_d = out_sum_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      carry_d   = carry_q;
      add_a     = '0;
      add_b     = '0;
      add_cin   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               a_d     = in_a;
               b_d     = in_b;
               carry_d = in_cin;
               idx_d   = '0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            add_a   = a_q[int'(idx_q)*WORD_W +: WORD_W];
            add_b   = b_q[int'(idx_q)*WORD_W +: WORD_W];
            add_cin = carry_q;
            cnt_d   = CNT_W'(ADD_LAT);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            // Counter at 1 marks the cycle the adder output belongs to this word
            if (cnt_q == CNT_W'(1)) begin
               out_sum_d[int'(idx_q)*WORD_W +: WORD_W] = add_sum;
               carry_d = add_cout;
               if (idx_q == IDX_W'(NWORDS - 1)) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = S_ISSUE;
               end
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      in_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         out_sum_q  <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
         carry_q    <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         out_sum_q  <= out_sum_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         carry_q    <= carry_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q == S_DONE);
   assign out_sum   = out_sum_q;
   assign out_cout  = carry_q;

`ifdef WADD_OVF_EN
   logic ovf_q, ovf_d;

   // Overflow uses the top word's sum MSB, captured together with that word
   always_comb begin
      ovf_d = ovf_q;
      if (state_q == S_WAIT && cnt_q == CNT_W'(1) && idx_q == IDX_W'(NWORDS - 1))
         ovf_d = (a_q[FULL_W-1] == b_q[FULL_W-1]) && (add_sum[WORD_W-1] != a_q[FULL_W-1]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ovf_q <= 1'b0;
      else     ovf_q <= ovf_d;
   end

   assign out_ovf = ovf_q;
`else
   assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed bench for wide_add_seq with a registered 1-cycle adder model.
module tb_wide_add_seq;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] in_a = '0;
   logic [127:0] in_b = '0;
   logic         in_cin = 1'b0;
   logic [31:0]  add_a, add_b, add_sum;
   logic         add_cin, add_cout;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [127:0] out_sum;
   logic         out_cout;
   logic         out_ovf;

   int checks = 0;
   int errors = 0;
   int cyc_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Registered adder stage, latency 1
   always @(posedge clk) {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

   wide_add_seq #(.WORD_W(32), .NWORDS(4), .ADD_LAT(1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one op at a negedge; returns at the negedge where out_valid is seen (or timeout).
   task automatic run_op(input logic [127:0] a, input logic [127:0] b, input logic cin, output int lat);
      int w;
      in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 30) begin
         @(negedge clk);
         w++;
      end
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) in_valid = 1'b0;
      end while (!out_valid && lat < 50);
   endtask

   initial begin
      int lat;
      int pulses;
      int t_prev;
      logic [127:0] held;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_add_a", add_a, 0);
      chk("rst_ovf", out_ovf, 0);
      rst = 1'b0;
      #1 chk("in_ready_after_deassert", in_ready, 0);
      @(negedge clk);
      chk("in_ready_first_edge", in_ready, 1);

      // 1) Carry ripple across all words
      run_op({128{1'b1}}, 128'h1, 1'b0, lat);
      chk("ripple_lat", lat, 9);
      chk("ripple_sum", out_sum, 128'h0);
      chk("ripple_cout", out_cout, 1);
      @(negedge clk);
      chk("ripple_valid_drop", out_valid, 0);
      chk("ripple_in_ready_next", in_ready, 1);

      // 2) Carry-in only
      run_op(128'h0, 128'h0, 1'b1, lat);
      chk("cin_lat", lat, 9);
      chk("cin_sum", out_sum, 128'h1);
      chk("cin_cout", out_cout, 0);

      // 3) Backpressure in DONE
      @(negedge clk);
      out_ready = 1'b0;
      run_op(128'h00000001_FFFFFFFF_00000000_FFFFFFFF, 128'h00000001_00000001_00000000_00000001, 1'b0, lat);
      chk("bp_lat", lat, 9);
      held = out_sum;
      chk("bp_sum", out_sum, 128'h00000003_00000000_00000001_00000000);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid_hold", out_valid, 1);
         chk("bp_sum_hold", out_sum, held);
         chk("bp_in_ready_low", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_one_handshake", out_valid, 0);
      chk("bp_in_ready_after", in_ready, 1);

      // 4) Reset during WAIT of word 2 (cycle 6 after accept)
      in_a = {128{1'b1}}; in_b = 128'h1; in_cin = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_out_sum", out_sum, 0);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_add_a", add_a, 0);
      chk("mid_rst_add_b", add_b, 0);
      chk("mid_rst_cout", out_cout, 0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      chk("mid_rst_no_pulse", pulses, 0);
      run_op(128'hFFFFFFFF_00000000_00000000_00000000, 128'h00000001_00000000_00000000_00000000, 1'b1, lat);
      chk("post_rst_lat", lat, 9);
      chk("post_rst_sum", out_sum, 128'h1);
      chk("post_rst_cout", out_cout, 1);
      @(negedge clk);

      // 5) Back-to-back with in_valid and out_ready held high
      in_a = 128'h12345678_9ABCDEF0_0F0F0F0F_80000000;
      in_b = 128'h11111111_11111111_F0F0F0F0_80000000;
      in_cin = 1'b0; in_valid = 1'b1;
      lat = 0;
      while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
      chk("b2b0_sum", out_sum, 128'h23456789_ABCDF002_00000000_00000000);
      chk("b2b0_cout", out_cout, 0);
      t_prev = cyc_cnt;
      in_a = {128{1'b1}}; in_b = 128'h1; in_cin = 1'b0;
      @(negedge clk);
      lat = 0;
      while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
      chk("b2b1_space", cyc_cnt - t_prev, 10);
      chk("b2b1_sum", out_sum, 128'h0);
      chk("b2b1_cout", out_cout, 1);
      t_prev = cyc_cnt;
      in_a = 128'hFFFFFFFF_00000000_00000000_00000000;
      in_b = 128'h00000001_00000000_00000000_00000000;
      in_cin = 1'b1;
      @(negedge clk);
      lat = 0;
      while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
      chk("b2b2_space", cyc_cnt - t_prev, 10);
      chk("b2b2_sum", out_sum, 128'h1);
      chk("b2b2_cout", out_cout, 1);
      in_valid = 1'b0;
      @(negedge clk);

      // 6) Signed overflow
      run_op({1'b0, {127{1'b1}}}, 128'h1, 1'b0, lat);
      chk("ovf1_sum", out_sum, {1'b1, 127'h0});
      chk("ovf1_cout", out_cout, 0);
`ifdef WADD_OVF_EN
      chk("ovf1_flag", out_ovf, 1);
`else
      chk("ovf1_flag_off", out_ovf, 0);
`endif
      @(negedge clk);
      run_op({1'b0, {127{1'b1}}}, {1'b1, 127'h0}, 1'b0, lat);
      chk("ovf0_sum", out_sum, {128{1'b1}});
      chk("ovf0_flag", out_ovf, 0);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
